// File: rtl/pe_block.sv
// rtl/pe_block.sv - systolic MAC block of BLOCK_NUM rows x ARRAY_NUM PEs with pass-left forwarding
// Optional output saturation after the window shift is enabled by defining PE_SATURATE_EN.
module pe_block #(
    parameter int ARRAY_NUM = 3,
    parameter int BLOCK_NUM = 3,
    parameter int ACC_W     = 24
) (
    input  logic                               iClk,
    input  logic                               iRst,
    input  logic                               iClearAcc,
    input  logic [ARRAY_NUM-2:0]               iCfsPassDataLeft,
    input  logic [8*ARRAY_NUM*BLOCK_NUM-1:0]   iData,
    input  logic signed [7:0]                  iWeight,
    input  logic [4:0]                         iCfsOutputLeftShift,
    output logic [8*ARRAY_NUM*BLOCK_NUM-1:0]   oResult
);

`ifdef PE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return 8'h7f;
        end else if (v < SAT_MIN) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction
`endif

    for (genvar b = 0; b < BLOCK_NUM; b++) begin : g_row
        for (genvar j = 0; j < ARRAY_NUM; j++) begin : g_pe
            localparam int L = b * ARRAY_NUM + j;

            logic signed [7:0]       op;
            logic signed [15:0]      prod;
            logic signed [ACC_W-1:0] acc;

            // The last PE has no right-hand neighbour, so it always reads its own lane.
            if (j == ARRAY_NUM - 1) begin : g_last
                assign op = $signed(iData[8*L +: 8]);
            end else begin : g_mid
                assign op = iCfsPassDataLeft[j] ? g_pe[j+1].g_fwd.fwd
                                                : $signed(iData[8*L +: 8]);
            end

            // PE 0 has no left-hand consumer, so its forwarding register is not kept.
            if (j > 0) begin : g_fwd
                logic signed [7:0] fwd;
                always_ff @(posedge iClk or negedge iRst) begin
                    if (!iRst) begin
                        fwd <= '0;
                    end else begin
                        fwd <= op;
                    end
                end
            end

            assign prod = op * iWeight;

            always_ff @(posedge iClk or negedge iRst) begin
                if (!iRst) begin
                    acc <= '0;
                end else if (iClearAcc) begin
                    acc <= '0;
                end else begin
                    acc <= acc + {{(ACC_W-16){prod[15]}}, prod};
                end
            end

`ifdef PE_SATURATE_EN
            logic signed [ACC_W-1:0] shifted;
            assign shifted            = acc >>> iCfsOutputLeftShift;
            assign oResult[8*L +: 8]  = sat8(shifted);
`else
            assign oResult[8*L +: 8]  = 8'(acc >>> iCfsOutputLeftShift);
`endif
        end
    end

endmodule

// File: tb/tb_pe_block.sv
// tb/tb_pe_block.sv - directed self-checking bench for pe_block
module tb_pe_block;
    localparam int AN = 3;
    localparam int BN = 3;
    localparam int AW = 24;
    localparam int NL = AN * BN;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic [AN-2:0]     pass = '0;
    logic [8*NL-1:0]   data = '0;
    logic signed [7:0] weight = '0;
    logic [4:0]        shift = '0;
    logic [8*NL-1:0]   res;

    int passed = 0;
    int total  = 0;

    pe_block #(.ARRAY_NUM(AN), .BLOCK_NUM(BN), .ACC_W(AW)) dut (
        .iClk(clk),
        .iRst(rst_n),
        .iClearAcc(clear),
        .iCfsPassDataLeft(pass),
        .iData(data),
        .iWeight(weight),
        .iCfsOutputLeftShift(shift),
        .oResult(res)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [7:0] v);
        data[8*lane +: 8] = v;
    endtask

    task automatic chk(input string tag, input int lane, input logic [7:0] exp);
        logic [7:0] got;
        got = res[8*lane +: 8];
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s lane%0d observed=0x%02h expected=0x%02h", tag, lane, got, exp);
    endtask

    initial begin
        // reset held with random stimulus
        for (int i = 0; i < NL; i++) set_lane(i, 8'($urandom));
        weight = 8'($urandom);
        tick();
        tick();
        tick();
        for (int i = 0; i < NL; i++) chk("reset_hold", i, 8'h00);
        data = '0;
        weight = '0;
        #2 rst_n = 1'b1;
        #1 chk("reset_release", 0, 8'h00);
        tick();

        // single MAC: 1*1 + 2*2 + 3*3 = 14
        set_lane(0, 8'd1);
        set_lane(4, 8'hFB);
        set_lane(8, 8'd10);
        weight = 8'sd1;
        tick();
        chk("mac_first", 0, 8'd1);
        chk("mac_first", 4, 8'hFB);
        chk("mac_first", 8, 8'd10);
        set_lane(0, 8'd2);
        weight = 8'sd2;
        tick();
        set_lane(0, 8'd3);
        weight = 8'sd3;
        tick();
        chk("mac_sum", 0, 8'd14);
        chk("mac_sum", 4, 8'hE2);
        chk("mac_sum", 8, 8'd60);
        chk("mac_idle", 1, 8'h00);

        clear = 1'b1;
        data = '0;
        tick();
        clear = 1'b0;
        chk("clear_all", 0, 8'h00);
        chk("clear_all", 8, 8'h00);

        // pass-left: PE1 forwards 6 into PE0
        set_lane(1, 8'd6);
        weight = 8'sd2;
        tick();
        chk("pass_pre", 1, 8'd12);
        pass = 2'b01;
        weight = 8'sd4;
        set_lane(1, 8'd1);
        set_lane(0, 8'd99);
        tick();
        chk("pass_fwd", 0, 8'd24);
        chk("pass_own", 1, 8'd16);
        chk("pass_row1", 3, 8'h00);

        pass = '0;
        clear = 1'b1;
        data = '0;
        tick();
        clear = 1'b0;

        // clear priority
        set_lane(0, 8'd5);
        weight = 8'sd10;
        tick();
        chk("clr_acc50", 0, 8'd50);
        clear = 1'b1;
        weight = 8'sd5;
        tick();
        chk("clr_prio", 0, 8'h00);
        clear = 1'b0;
        tick();
        chk("clr_after", 0, 8'd25);

        // asynchronous reset mid-stream, then restart with no residue
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_restart", 0, 8'd25);

        // positive accumulator 1000, shift window
        clear = 1'b1;
        data = '0;
        tick();
        clear = 1'b0;
        set_lane(0, 8'd100);
        weight = 8'sd10;
        tick();
        data = '0;
        weight = '0;
`ifdef PE_SATURATE_EN
        chk("pos_sh0", 0, 8'h7F);
`else
        chk("pos_sh0", 0, 8'hE8);
`endif
        shift = 5'd3;
        #1 chk("pos_sh3", 0, 8'd125);
        shift = 5'd23;
        #1 chk("pos_sh23", 0, 8'h00);
        shift = 5'd31;
        #1 chk("pos_sh31", 0, 8'h00);

        // negative accumulator -16256
        shift = 5'd0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_lane(0, 8'h80);
        weight = 8'sd127;
        tick();
        data = '0;
        weight = '0;
        chk("neg_sh0", 0, 8'h80);
        shift = 5'd4;
`ifdef PE_SATURATE_EN
        #1 chk("neg_sh4", 0, 8'h80);
`else
        #1 chk("neg_sh4", 0, 8'h08);
`endif
        shift = 5'd23;
        #1 chk("neg_sh23", 0, 8'hFF);
        shift = 5'd31;
        #1 chk("neg_sh31", 0, 8'hFF);

        // rows independent under a full pass chain
        shift = 5'd0;
        clear = 1'b1;
        data = '0;
        tick();
        clear = 1'b0;
        pass = 2'b11;
        weight = 8'sd1;
        for (int b = 0; b < BN; b++)
            for (int j = 0; j < AN; j++)
                set_lane(b * AN + j, 8'(10 * (b + 1) + j));
        tick();
        tick();
        tick();
        chk("rows_b0", 0, 8'd12);
        chk("rows_b0", 1, 8'd24);
        chk("rows_b0", 2, 8'd36);
        chk("rows_b1", 3, 8'd22);
        chk("rows_b1", 4, 8'd44);
        chk("rows_b1", 5, 8'd66);
        chk("rows_b2", 6, 8'd32);
        chk("rows_b2", 7, 8'd64);
        chk("rows_b2", 8, 8'd96);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pe_block.md
Name: pe_block

Overview:
- Systolic MAC block: BLOCK_NUM rows, each a 1-D chain of ARRAY_NUM processing elements (PEs), so ARRAY_NUM*BLOCK_NUM PEs in total.
- Each PE multiplies an 8-bit signed activation by a broadcast 8-bit signed weight and accumulates the product.
- A PE can take its activation from the primary input or from its right-hand neighbour's forwarded register (sliding-window convolution).
- Instantiated by the array top; feeds the output/requantisation stage.

Parameters:
- ARRAY_NUM, 3, PEs per row (chain length); must be >= 2.
- BLOCK_NUM, 3, number of independent rows.
- ACC_W, 24, accumulator width in bits; must be >= 17.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  reset, asynchronous, active-low.
- iClearAcc  in  1  synchronous clear of all accumulators.
- iCfsPassDataLeft  in  ARRAY_NUM-1  bit j set: PE j in every row uses PE j+1's forwarded data.
- iData  in  8*ARRAY_NUM*BLOCK_NUM  activations; row b, PE j at bits [8*(b*ARRAY_NUM+j) +: 8].
- iWeight  in  8  signed weight, broadcast to all PEs.
- iCfsOutputLeftShift  in  5  output window position (shift amount).
- oResult  out  8*ARRAY_NUM*BLOCK_NUM  per-PE 8-bit result, same packing as iData.

Behaviour:
- Per PE (row b, index j), operand selection:
  - op = iCfsPassDataLeft[j] ? fwd[b][j+1] : iData lane (b,j).
  - The last PE (j = ARRAY_NUM-1) always uses iData.
- Registers, each rising edge:
  - fwd[b][j] <= op (8-bit forwarding register).
  - acc[b][j] <= iClearAcc ? 0 : acc + sext(op*iWeight).
- Arithmetic:
  - Product is signed 8x8 -> 16-bit, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no overflow flag.
- Clear priority: iClearAcc overrides accumulation in the same cycle (product discarded). fwd still loads op.
- Forwarding:
  - One-cycle hop per PE; a chain of passes moves data left one PE per cycle.
  - Passing never crosses row boundaries.
- Output:
  - oResult lane = sat8(acc >>> iCfsOutputLeftShift), an arithmetic shift.
  - Purely combinational from acc, so an input at edge N is visible after edge N.
- Shift boundaries:
  - Shift 0 gives the low 8 bits saturated.
  - Shifts >= ACC_W-1 give 0 for positive acc and -1 for negative acc.
- Reset: all acc and fwd registers go to 0 asynchronously, so oResult = 0. Deasserting reset mid-stream restarts from 0 with no residual data.
- Weight and shift are sampled every cycle; there is no handshake or stall.

Optional Feature:
- Macro: PE_SATURATE_EN.
- Defined: output saturates to [-128,127] after the shift.
- Undefined: output is the low 8 bits of the shifted accumulator (wrap).
- Accumulator behaviour is identical in both cases.

Test Plan:
- Reset: hold iRst=0 with random iData and weight -> all oResult = 0; release -> still 0 until the first edge.
- Single MAC: lane(0,0) = 1,2,3 with weights 1,2,3 over three cycles, shift 0 -> oResult lane(0,0) = 14; other lanes follow their own data*weight.
- Pass-left:
  - Cycle 1: lane(0,1) = 6, weight 2.
  - Cycle 2: pass bit0 = 1, weight 4.
  - Result: lane(0,0) accumulates 6*4 = 24 from the forwarded value; lane(0,1) = 12 plus its own new product.
- Clear: accumulate to 50, then assert iClearAcc with data 5 and weight 5 -> result 0, next cycle 25.
- Saturation and shift:
  - acc = 1000, shift 0 -> 127 with PE_SATURATE_EN, 0xE8 without.
  - shift 3 -> 125.
  - data -128, weight 127, shift 0 -> -128.
- Rows independent: different data in rows 0, 1, 2 with pass bits 11 -> no value crosses between rows; lane(b,2) uses only iData.
